// File: rtl/fnd_pkg.sv
// ---------------------------------------------------------------------------
// fnd_pkg
// Shared definitions for the multiplexed 7-segment (FND) display back-end:
//   DIGITS          number of scanned digit commons
//   bcd_t           one 4-bit BCD digit
//   SEG_0..SEG_OFF  common-anode segment patterns {dp,g,f,e,d,c,b,a}
//   conv_state_e    binary-to-BCD conversion FSM states
//   seg_decode()    BCD digit -> segment pattern (dp bit left dark)
//   dabble_step()   one shift-add-3 step on a {tens,ones,binary} vector
// ---------------------------------------------------------------------------
package fnd_pkg;

    localparam int DIGITS = 4;

    typedef logic [3:0] bcd_t;

    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_e;

    function automatic logic [7:0] seg_decode(input bcd_t digit);
        case (digit)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_OFF;
        endcase
    endfunction

    // Vector layout is {tens[15:12], ones[11:8], binary[7:0]}. Inputs are
    // saturated to 99 beforehand, so nothing is ever lost off the top.
    function automatic logic [15:0] dabble_step(input logic [15:0] v);
        logic [15:0] t;
        t = v;
        if (t[11:8] >= 4'd5)  t[11:8]  = t[11:8]  + 4'd3;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        return {t[14:0], 1'b0};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter for one 8-bit value (0..99) into two BCD
// digits. i_load captures the binary value, then each i_step cycle performs
// one add-3/shift; eight steps complete the conversion.
// Ports:
//   clk        system clock
//   i_reset_p  synchronous active-high reset
//   i_load     capture i_bin and restart the conversion
//   i_step     perform one shift-add-3 step
//   i_bin      binary input, must be <= 99
//   o_tens     BCD tens digit (valid after the eighth step)
//   o_ones     BCD ones digit (valid after the eighth step)
//   o_done     high during the eighth (final) step
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic       clk,
    input  logic       i_reset_p,
    input  logic       i_load,
    input  logic       i_step,
    input  logic [7:0] i_bin,
    output bcd_t       o_tens,
    output bcd_t       o_ones,
    output logic       o_done
);

    logic [15:0] r_shift;
    logic [2:0]  r_steps;

    // NOTE: state is written with non-blocking <= so every flop samples the
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (i_reset_p) begin
            r_shift <= '0;
            r_steps <= '0;
        end else if (i_load) begin
            r_shift <= {8'd0, i_bin};
            r_steps <= '0;
        end else if (i_step) begin
            r_shift <= dabble_step(r_shift);
            r_steps <= r_steps + 3'd1;
        end
    end

    assign o_tens = r_shift[15:12];
    assign o_ones = r_shift[11:8];
    assign o_done = i_step && (r_steps == 3'd7);

endmodule

// File: rtl/fnd_scan_display.sv
// ---------------------------------------------------------------------------
// fnd_scan_display
// Shows two 8-bit values as four BCD digits on a multiplexed 7-segment FND.
// Conversion runs during digit 3's period; results commit on the first cycle
// of the following digit-0 period so a frame never mixes old and new digits.
// Optional build macro: FND_BLINK_EN (2 Hz per-pair blanking via blink).
// Ports:
//   clk       system clock
//   reset_p   synchronous active-high reset
//   value_hi  left pair value (digits 3,2)
//   value_lo  right pair value (digits 1,0)
//   dp_en     light the decimal point on digit 2
//   blink     bit1 blanks the hi pair, bit0 the lo pair (FND_BLINK_EN only)
//   seg_n     segments {dp,g,f,e,d,c,b,a}
//   com_n     one-hot digit select, digit 0 rightmost
//   ovf       a value of the committed frame was > 99
// ---------------------------------------------------------------------------
module fnd_scan_display
    import fnd_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [7:0] value_hi,
    input  logic [7:0] value_lo,
    input  logic       dp_en,
    input  logic [1:0] blink,
    output logic [7:0] seg_n,
    output logic [3:0] com_n,
    output logic       ovf
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    // The 10-cycle conversion must fit inside a single digit period.
    generate
        if (DIV < 16) begin : g_div_too_small
            $error("fnd_scan_display: CLK_HZ/SCAN_HZ must be at least 16");
        end
    endgenerate

    logic [DIV_W-1:0]        r_div_cnt;
    logic [1:0]              r_digit;
    conv_state_e             r_state;
    conv_state_e             w_state_nxt;
    logic                    r_ovf_pend;
    logic                    r_ovf_shadow;
    logic                    r_ovf;
    bcd_t [DIGITS-1:0]       r_shadow;
    bcd_t [DIGITS-1:0]       r_disp;
    bcd_t [DIGITS-1:0]       w_frame_bcd;
    logic [7:0]              r_seg_n;
    logic [3:0]              r_com_n;
    logic [7:0]              w_seg_n;
    logic                    w_tick;
    logic                    w_frame_start;
    logic                    w_conv_start;
    logic                    w_blank;
    logic [7:0]              w_sat_hi;
    logic [7:0]              w_sat_lo;
    bcd_t                    w_tens_hi, w_ones_hi, w_tens_lo, w_ones_lo;
    logic                    w_done_hi, w_done_lo;

    assign w_tick        = (r_div_cnt == DIV_W'(DIV - 1));
    assign w_frame_start = (r_digit == 2'd0) && (r_div_cnt == '0);
    assign w_conv_start  = (r_digit == 2'd3) && (r_div_cnt == '0);

    // ---- scan divider and digit index ------------------------------------
    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_div_cnt <= '0;
            r_digit   <= 2'd0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_digit   <= r_digit + 2'd1;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // ---- conversion FSM --------------------------------------------------
    // NOTE: combinational blocks assign a default before any branch so every
    // path drives every output and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_conv_start) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = SHIFT;
            SHIFT:   if (w_done_hi && w_done_lo) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_sat_hi = (value_hi > 8'd99) ? 8'd99 : value_hi;
    assign w_sat_lo = (value_lo > 8'd99) ? 8'd99 : value_lo;

    bin2bcd_seq u_conv_hi (
        .clk       (clk),
        .i_reset_p (reset_p),
        .i_load    (r_state == LOAD),
        .i_step    (r_state == SHIFT),
        .i_bin     (w_sat_hi),
        .o_tens    (w_tens_hi),
        .o_ones    (w_ones_hi),
        .o_done    (w_done_hi)
    );

    bin2bcd_seq u_conv_lo (
        .clk       (clk),
        .i_reset_p (reset_p),
        .i_load    (r_state == LOAD),
        .i_step    (r_state == SHIFT),
        .i_bin     (w_sat_lo),
        .o_tens    (w_tens_lo),
        .o_ones    (w_ones_lo),
        .o_done    (w_done_lo)
    );

    // Shadow registers only change in DONE, so a reset mid-conversion leaves
    // nothing half-written to commit.
    // NOTE: these digit banks are a handful of flops, not a RAM, so they are
    // cleared in reset; the display must start from a known all-zero frame.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_state      <= IDLE;
            r_ovf_pend   <= 1'b0;
            r_ovf_shadow <= 1'b0;
            r_shadow     <= '0;
            r_disp       <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == LOAD)
                r_ovf_pend <= (value_hi > 8'd99) || (value_lo > 8'd99);
            if (r_state == DONE) begin
                r_shadow     <= {w_tens_hi, w_ones_hi, w_tens_lo, w_ones_lo};
                r_ovf_shadow <= r_ovf_pend;
            end
            if (w_frame_start) begin
                r_disp <= r_shadow;
                r_ovf  <= r_ovf_shadow;
            end
        end
    end

    // ---- optional blink phase --------------------------------------------
`ifdef FND_BLINK_EN
    // Phase toggles every SCAN_HZ/4 scan ticks: a CLK_HZ/2-cycle period.
    localparam int BLINK_TICKS = (SCAN_HZ / 4 > 0) ? SCAN_HZ / 4 : 1;
    localparam int BLINK_W     = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_phase;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_tick) begin
            if (r_blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Digits 3,2 belong to the hi pair, digits 1,0 to the lo pair.
    assign w_blank = r_phase && (r_digit[1] ? blink[1] : blink[0]);
`else
    logic w_unused_blink;
    assign w_unused_blink = ^blink;
    assign w_blank        = 1'b0;
`endif

    // ---- segment and common drive ----------------------------------------
    // On the commit cycle the new digits are taken straight from the shadow
    // so digit 0's first registered cycle already shows the new frame.
    assign w_frame_bcd = w_frame_start ? r_shadow : r_disp;

    always_comb begin
        w_seg_n    = seg_decode(w_frame_bcd[r_digit]);
        w_seg_n[7] = !((r_digit == 2'd2) && dp_en);
        if (w_blank)
            w_seg_n = SEG_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_seg_n <= SEG_OFF;
            r_com_n <= 4'hF;
        end else begin
            r_seg_n <= w_seg_n;
            r_com_n <= ~(4'b0001 << r_digit);
        end
    end

    assign seg_n = COMMON_ANODE ? r_seg_n : ~r_seg_n;
    assign com_n = COMMON_ANODE ? r_com_n : ~r_com_n;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_fnd_scan_display.sv
// ---------------------------------------------------------------------------
// tb_fnd_scan_display
// Directed bench for fnd_scan_display at CLK_HZ=1600, SCAN_HZ=100 (DIV=16,
// one frame = 64 cycles). Inputs change and outputs are sampled on the
// falling clock edge. Define FND_BLINK_EN to also exercise blinking.
// ---------------------------------------------------------------------------
module tb_fnd_scan_display;

    localparam int CLK_HZ  = 1600;
    localparam int SCAN_HZ = 100;
    localparam int FRAME   = 64;

    logic       clk      = 1'b0;
    logic       reset_p  = 1'b1;
    logic [7:0] value_hi = 8'd0;
    logic [7:0] value_lo = 8'd0;
    logic       dp_en    = 1'b0;
    logic [1:0] blink    = 2'b00;
    logic [7:0] seg_n;
    logic [3:0] com_n;
    logic       ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fnd_scan_display #(
        .CLK_HZ       (CLK_HZ),
        .SCAN_HZ      (SCAN_HZ),
        .COMMON_ANODE (1'b1)
    ) dut (
        .clk      (clk),
        .reset_p  (reset_p),
        .value_hi (value_hi),
        .value_lo (value_lo),
        .dp_en    (dp_en),
        .blink    (blink),
        .seg_n    (seg_n),
        .com_n    (com_n),
        .ovf      (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance (on falling edges) until digit d is being driven; bounded.
    task automatic wait_digit(input int d);
        logic [3:0] target;
        bit         found;
        target = ~(4'b0001 << d[1:0]);
        found  = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (com_n === target) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found)
            check($sformatf("wait_digit%0d", d), {28'd0, com_n}, {28'd0, target});
    endtask

    task automatic check_digit(input string tag, input int d, input logic [7:0] exp);
        wait_digit(d);
        check(tag, {24'd0, seg_n}, {24'd0, exp});
    endtask

    task automatic wait_frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    initial begin
        logic [7:0] seen;

        // ---- reset ---------------------------------------------------------
        repeat (3) @(negedge clk);
        check("rst_com",  {28'd0, com_n}, 32'hF);
        check("rst_seg",  {24'd0, seg_n}, 32'hFF);
        check("rst_ovf",  {31'd0, ovf},   32'd0);
        reset_p = 1'b0;
        @(negedge clk);
        check("post_rst_com", {28'd0, com_n}, 32'hE);
        check("post_rst_seg", {24'd0, seg_n}, 32'hC0);

        // ---- normal display 59 / 07 with dp on digit 2 ---------------------
        value_hi = 8'd59;
        value_lo = 8'd7;
        dp_en    = 1'b1;
        wait_frames(3);
        check_digit("norm_d3", 3, 8'h92);
        check_digit("norm_d2", 2, 8'h10);
        check_digit("norm_d1", 1, 8'hC0);
        check_digit("norm_d0", 0, 8'hF8);
        check("norm_ovf", {31'd0, ovf}, 32'd0);

        // ---- overflow saturation -------------------------------------------
        dp_en    = 1'b0;
        value_hi = 8'd150;
        value_lo = 8'd200;
        wait_frames(3);
        check_digit("ovf_d3", 3, 8'h90);
        check_digit("ovf_d2", 2, 8'h90);
        check_digit("ovf_d1", 1, 8'h90);
        check_digit("ovf_d0", 0, 8'h90);
        check("ovf_flag", {31'd0, ovf}, 32'd1);
        value_hi = 8'd42;
        value_lo = 8'd42;
        wait_frames(3);
        check("ovf_clear", {31'd0, ovf}, 32'd0);
        check_digit("ovf42_d3", 3, 8'h99);
        check_digit("ovf42_d0", 0, 8'hA4);

        // ---- no tearing: change lo during digit 1 --------------------------
        value_hi = 8'd12;
        value_lo = 8'd12;
        wait_frames(3);
        check_digit("tear_d1_before", 1, 8'hF9);
        value_lo = 8'd34;
        seen = 8'hF9;
        for (int i = 0; i < FRAME && com_n === 4'b1101; i++) begin
            if (seg_n !== 8'hF9) seen = seg_n;
            @(negedge clk);
        end
        check("tear_d1_hold", {24'd0, seen}, 32'hF9);
        check_digit("tear_d2_old", 2, 8'hA4);
        check_digit("tear_d0_new", 0, 8'h99);
        check_digit("tear_d1_new", 1, 8'hB0);

        // ---- reset during SHIFT --------------------------------------------
        value_hi = 8'd150;
        value_lo = 8'd200;
        wait_frames(3);
        check("mid_pre_ovf", {31'd0, ovf}, 32'd1);
        wait_digit(2);
        wait_digit(3);
        repeat (3) @(negedge clk);
        reset_p = 1'b1;
        @(negedge clk);
        check("mid_rst_com", {28'd0, com_n}, 32'hF);
        check("mid_rst_seg", {24'd0, seg_n}, 32'hFF);
        check("mid_rst_ovf", {31'd0, ovf},   32'd0);
        reset_p = 1'b0;
        @(negedge clk);
        check("mid_d0_zero", {24'd0, seg_n}, 32'hC0);
        check_digit("mid_d1_zero", 1, 8'hC0);
        check_digit("mid_d2_zero", 2, 8'hC0);
        check_digit("mid_d3_zero", 3, 8'hC0);
        check("mid_ovf_zero", {31'd0, ovf}, 32'd0);
        check_digit("mid_d0_fresh", 0, 8'h90);
        check("mid_ovf_fresh", {31'd0, ovf}, 32'd1);

`ifdef FND_BLINK_EN
        // ---- blink hi pair -------------------------------------------------
        blink    = 2'b10;
        value_hi = 8'd59;
        value_lo = 8'd7;
        reset_p  = 1'b1;
        repeat (2) @(negedge clk);
        reset_p  = 1'b0;
        repeat (150) @(negedge clk);
        check_digit("blink_ph0_d3", 3, 8'h92);
        check_digit("blink_ph0_d0", 0, 8'hF8);
        repeat (280) @(negedge clk);
        check_digit("blink_ph1_d3", 3, 8'hFF);
        check_digit("blink_ph1_d0", 0, 8'hF8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
